ll_ptr_manager: RTL and testbench

LL_PTR_MANAGER -- requirements
Module: ll_ptr_manager

---
 rtl/ll_pkg.sv | 18 +
 rtl/ll_ptr_bitmap.sv | 52 +++++
 rtl/ll_ptr_manager.sv | 161 ++++++++++++++++
 tb/tb_ll_ptr_manager.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// ---------------------------------------------------------------------------
// ll_pkg -- shared definitions for the linked-list pointer manager.
//   LL_A_WIDTH : default pointer width (pointer space is 2**LL_A_WIDTH).
//   ll_ptr_t   : pointer type at the default width.
//   pf_state_e : prefetch register state (PF_EMPTY / PF_FULL).
// ---------------------------------------------------------------------------
package ll_pkg;

    localparam int LL_A_WIDTH = 8;

    typedef logic [LL_A_WIDTH-1:0] ll_ptr_t;

    typedef enum logic {
        PF_EMPTY = 1'b0,
        PF_FULL  = 1'b1
    } pf_state_e;

endpackage

// File: rtl/ll_ptr_bitmap.sv
// ---------------------------------------------------------------------------
// ll_ptr_bitmap -- one in-use bit per pointer, used to catch double frees.
// Only built when LL_DOUBLE_FREE_CHECK_EN is defined.
//   clk_i, rst_i     : clock, synchronous active-high reset (clears all bits)
//   set_i, set_ptr_i : mark a pointer as allocated
//   clr_i, clr_ptr_i : mark a pointer as free
//   test_ptr_i       : pointer to look up
//   test_o           : current (registered) in-use bit of test_ptr_i
// ---------------------------------------------------------------------------
module ll_ptr_bitmap
    import ll_pkg::*;
#(
    parameter int A_WIDTH = LL_A_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               set_i,
    input  logic [A_WIDTH-1:0] set_ptr_i,
    input  logic               clr_i,
    input  logic [A_WIDTH-1:0] clr_ptr_i,
    input  logic [A_WIDTH-1:0] test_ptr_i,
    output logic               test_o
);

    localparam int N_PTR = 2 ** A_WIDTH;

    logic [N_PTR-1:0] bits_q;
    logic [N_PTR-1:0] bits_d;

    // Clear is applied after set so a same-cycle set/clear of one pointer
    // leaves it free.
    always_comb begin
        bits_d = bits_q;
        if (set_i) begin
            bits_d[set_ptr_i] = 1'b1;
        end
        if (clr_i) begin
            bits_d[clr_ptr_i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign test_o = bits_q[test_ptr_i];

endmodule

// File: rtl/ll_ptr_manager.sv
// ---------------------------------------------------------------------------
// ll_ptr_manager -- hands out pointers from an external free-pointer store
// through a one-entry prefetch register and returns freed pointers to it.
//
// Optional feature: define LL_DOUBLE_FREE_CHECK_EN to add an in-use bitmap
// that rejects frees of pointers that are not currently allocated.
//
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   alloc_req_i               : allocation request, held until granted
//   alloc_gnt_o, alloc_ptr_o  : one-cycle grant and the granted pointer
//   free_val_i, free_ptr_i    : pointer release strobe and pointer
//   next_empty_ptr_i/_val_i   : head of the free-pointer store
//   next_empty_ptr_rd_ack_o   : pop of the store head
//   add_empty_ptr_o/_en_o     : push of a released pointer to the store
//   alloc_cnt_o               : number of pointers currently allocated
//   err_o                     : one-cycle pulse for an illegal free
//
// Prefetch FSM:
//   state    | meaning
//   PF_EMPTY | no pointer held; pop the store head as soon as it is valid
//   PF_FULL  | pf_ptr holds a pointer ready for a zero-latency grant
// ---------------------------------------------------------------------------
module ll_ptr_manager
    import ll_pkg::*;
#(
    parameter int A_WIDTH = LL_A_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               alloc_req_i,
    output logic               alloc_gnt_o,
    output logic [A_WIDTH-1:0] alloc_ptr_o,
    input  logic               free_val_i,
    input  logic [A_WIDTH-1:0] free_ptr_i,
    input  logic [A_WIDTH-1:0] next_empty_ptr_i,
    input  logic               next_empty_ptr_val_i,
    output logic               next_empty_ptr_rd_ack_o,
    output logic [A_WIDTH-1:0] add_empty_ptr_o,
    output logic               add_empty_ptr_en_o,
    output logic [A_WIDTH:0]   alloc_cnt_o,
    output logic               err_o
);

    localparam int CW = A_WIDTH + 1;

    pf_state_e          state_q;
    pf_state_e          state_d;
    logic [A_WIDTH-1:0] pf_ptr_q;
    logic [A_WIDTH-1:0] pf_ptr_d;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic               add_en_q;
    logic               add_en_d;
    logic [A_WIDTH-1:0] add_ptr_q;
    logic [A_WIDTH-1:0] add_ptr_d;
    logic               err_q;
    logic               err_d;

    logic               gnt;
    logic               rd_ack;
    logic               free_legal;
    logic               free_ok;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        gnt     = 1'b0;
        rd_ack  = 1'b0;
        if (!rst_i) begin
            gnt = (state_q == PF_FULL) && alloc_req_i;
            // A grant empties the register, so it may refill in the same
            // cycle; this is what sustains one grant per cycle.
            rd_ack = next_empty_ptr_val_i && ((state_q == PF_EMPTY) || gnt);
            if (rd_ack) begin
                state_d = PF_FULL;
            end else if (gnt) begin
                state_d = PF_EMPTY;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------- free legality
`ifdef LL_DOUBLE_FREE_CHECK_EN
    logic in_use;

    ll_ptr_bitmap #(
        .A_WIDTH (A_WIDTH)
    ) u_bitmap (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (gnt),
        .set_ptr_i  (pf_ptr_q),
        .clr_i      (free_ok),
        .clr_ptr_i  (free_ptr_i),
        .test_ptr_i (free_ptr_i),
        .test_o     (in_use)
    );

    assign free_legal = in_use;
`else
    assign free_legal = 1'b1;
`endif

    assign free_ok = free_val_i && (cnt_q != '0) && free_legal;

    // ---------------------------------------------------------- datapath
    always_comb begin
        pf_ptr_d  = pf_ptr_q;
        cnt_d     = cnt_q;
        add_en_d  = free_ok;
        add_ptr_d = add_ptr_q;
        err_d     = free_val_i && !free_ok;

        if (rd_ack) begin
            pf_ptr_d = next_empty_ptr_i;
        end
        if (free_ok) begin
            add_ptr_d = free_ptr_i;
        end

        unique case ({gnt, free_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pf_ptr_q  <= '0;
            cnt_q     <= '0;
            add_en_q  <= 1'b0;
            add_ptr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pf_ptr_q  <= pf_ptr_d;
            cnt_q     <= cnt_d;
            add_en_q  <= add_en_d;
            add_ptr_q <= add_ptr_d;
            err_q     <= err_d;
        end
    end

    assign alloc_gnt_o             = gnt;
    assign alloc_ptr_o             = pf_ptr_q;
    assign next_empty_ptr_rd_ack_o = rd_ack;
    assign add_empty_ptr_o         = add_ptr_q;
    assign add_empty_ptr_en_o      = add_en_q;
    assign alloc_cnt_o             = cnt_q;
    assign err_o                   = err_q;

endmodule

// File: tb/tb_ll_ptr_manager.sv
// ---------------------------------------------------------------------------
// tb_ll_ptr_manager -- self-checking bench for ll_ptr_manager (A_WIDTH=8).
// Each vector row is driven for one clock cycle; combinational outputs and
// alloc_cnt_o are compared against the row, while the registered free
// response (push / error) is predicted into a scoreboard queue and compared
// one cycle later. Honours LL_DOUBLE_FREE_CHECK_EN for the double-free case.
// ---------------------------------------------------------------------------
module tb_ll_ptr_manager;

    localparam int AW = 8;

    typedef struct {
        logic          rst;
        logic          req;
        logic          fv;
        logic [AW-1:0] fptr;
        logic          nv;
        logic [AW-1:0] nptr;
        logic          e_gnt;
        logic [AW-1:0] e_aptr;
        logic          e_ack;
        logic [AW:0]   e_cnt;
    } vec_t;

    typedef struct {
        logic          en;
        logic [AW-1:0] ptr;
        logic          err;
        logic          chk_ptr;
    } sb_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          alloc_req_i;
    logic          alloc_gnt_o;
    logic [AW-1:0] alloc_ptr_o;
    logic          free_val_i;
    logic [AW-1:0] free_ptr_i;
    logic [AW-1:0] next_empty_ptr_i;
    logic          next_empty_ptr_val_i;
    logic          next_empty_ptr_rd_ack_o;
    logic [AW-1:0] add_empty_ptr_o;
    logic          add_empty_ptr_en_o;
    logic [AW:0]   alloc_cnt_o;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t            vecs[$];
    vec_t            seq[$];
    sb_t             sbq[$];
    logic [2**AW-1:0] inuse_m;

    ll_ptr_manager #(.A_WIDTH(AW)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .alloc_req_i             (alloc_req_i),
        .alloc_gnt_o             (alloc_gnt_o),
        .alloc_ptr_o             (alloc_ptr_o),
        .free_val_i              (free_val_i),
        .free_ptr_i              (free_ptr_i),
        .next_empty_ptr_i        (next_empty_ptr_i),
        .next_empty_ptr_val_i    (next_empty_ptr_val_i),
        .next_empty_ptr_rd_ack_o (next_empty_ptr_rd_ack_o),
        .add_empty_ptr_o         (add_empty_ptr_o),
        .add_empty_ptr_en_o      (add_empty_ptr_en_o),
        .alloc_cnt_o             (alloc_cnt_o),
        .err_o                   (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(int rst, int req, int fv, int fptr, int nv, int nptr,
                                int gnt, int aptr, int ack, int cnt);
        vec_t v;
        v.rst    = rst[0];
        v.req    = req[0];
        v.fv     = fv[0];
        v.fptr   = AW'(fptr);
        v.nv     = nv[0];
        v.nptr   = AW'(nptr);
        v.e_gnt  = gnt[0];
        v.e_aptr = AW'(aptr);
        v.e_ack  = ack[0];
        v.e_cnt  = (AW+1)'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic run_row(input vec_t v, input int row);
        sb_t e;
        sb_t p;
        logic acc;
        rst_i                = v.rst;
        alloc_req_i          = v.req;
        free_val_i           = v.fv;
        free_ptr_i           = v.fptr;
        next_empty_ptr_val_i = v.nv;
        next_empty_ptr_i     = v.nptr;
        @(negedge clk_i);
        chk("gnt", row, 32'(alloc_gnt_o), 32'(v.e_gnt));
        if (v.e_gnt) chk("alloc_ptr", row, 32'(alloc_ptr_o), 32'(v.e_aptr));
        chk("rd_ack", row, 32'(next_empty_ptr_rd_ack_o), 32'(v.e_ack));
        chk("alloc_cnt", row, 32'(alloc_cnt_o), 32'(v.e_cnt));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("push_en", row, 32'(add_empty_ptr_en_o), 32'(e.en));
            chk("err", row, 32'(err_o), 32'(e.err));
            if (e.en || e.chk_ptr) chk("push_ptr", row, 32'(add_empty_ptr_o), 32'(e.ptr));
        end else begin
            chk("scoreboard_empty", row, 32'd1, 32'd0);
        end

        acc = !v.rst && v.fv && (v.e_cnt != '0);
`ifdef LL_DOUBLE_FREE_CHECK_EN
        acc = acc && inuse_m[v.fptr];
`endif
        p.en      = acc;
        p.ptr     = acc ? v.fptr : '0;
        p.err     = !v.rst && v.fv && !acc;
        p.chk_ptr = v.rst;
        sbq.push_back(p);

        if (v.rst) begin
            inuse_m = '0;
        end else begin
            if (v.e_gnt) inuse_m[v.e_aptr] = 1'b1;
            if (acc)     inuse_m[v.fptr]   = 1'b0;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        sb_t r;
        int  cnt_after;
        rst_i                = 1'b1;
        alloc_req_i          = 1'b0;
        free_val_i           = 1'b0;
        free_ptr_i           = '0;
        next_empty_ptr_val_i = 1'b0;
        next_empty_ptr_i     = '0;
        inuse_m              = '0;

        //            rst req fv fptr nv nptr  gnt aptr ack cnt
        vecs.push_back(mk(1, 1, 0, 0, 1,  3,  0,  0, 0, 0));  // held in reset
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0,  0, 0, 0));  // store initialising
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1,  0,  0,  0, 1, 0));  // first fill
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,  1,  0, 0, 0));  // grant ptr 0
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0,  0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1,  5,  0,  0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1,  6,  1,  5, 1, 1));  // back-to-back 5,6,7
        vecs.push_back(mk(0, 1, 0, 0, 1,  7,  1,  6, 1, 2));
        vecs.push_back(mk(0, 1, 0, 0, 1,  9,  1,  7, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 10,  0,  0, 0, 4));  // full, no pop
        vecs.push_back(mk(0, 0, 1, 6, 0,  0,  0,  0, 0, 4));  // free 6
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0,  0, 0, 3));
        vecs.push_back(mk(0, 1, 1, 5, 1, 11,  1,  9, 1, 3));  // grant 9 + free 5
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0,  0, 0, 3));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,  1, 11, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 12,  0,  0, 1, 4));  // full, cnt 4
        vecs.push_back(mk(1, 1, 1, 7, 1, 13,  0,  0, 0, 4));  // reset mid-op
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0,  0, 0, 0));  // prefetch dropped
        vecs.push_back(mk(0, 0, 1, 3, 0,  0,  0,  0, 0, 0));  // underflow free
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0,  0, 0, 0));

`ifdef LL_DOUBLE_FREE_CHECK_EN
        cnt_after = 1;
`else
        cnt_after = 0;
`endif
        // Double free of pointer 6 while pointer 8 keeps the count non-zero.
        seq.push_back(mk(0, 1, 0, 0, 1, 6, 0, 0, 1, 0));
        seq.push_back(mk(0, 1, 0, 0, 1, 8, 1, 6, 1, 0));
        seq.push_back(mk(0, 1, 0, 0, 0, 0, 1, 8, 0, 1));
        seq.push_back(mk(0, 0, 1, 6, 0, 0, 0, 0, 0, 2));
        seq.push_back(mk(0, 0, 1, 6, 0, 0, 0, 0, 0, 1));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, cnt_after));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, cnt_after));

        repeat (2) @(posedge clk_i);
        #1;
        r.en = 1'b0; r.ptr = '0; r.err = 1'b0; r.chk_ptr = 1'b1;
        sbq.push_back(r);

        for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);
        for (int i = 0; i < seq.size(); i++) run_row(seq[i], 100 + i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
